// File: rtl/ex_mem_pkg.sv
// Shared types for the EX->MEM pipeline register: control bundle, zero-register id and bubble gating.
package ex_mem_pkg;

    typedef struct packed {
        logic RegWrite;
        logic MemtoReg;
        logic MemWrite;
        logic MemRead;
    } ex_mem_ctrl_t;

    localparam int CTRL_W   = $bits(ex_mem_ctrl_t);
    localparam int ZERO_REG = 0;

    // A bubble must never carry live control into MEM/WB.
    function automatic ex_mem_ctrl_t gate_ctrl(input ex_mem_ctrl_t ctrl, input logic valid);
        return valid ? ctrl : '0;
    endfunction

endpackage

// File: rtl/ex_mem_slot.sv
// One pipeline entry: valid bit plus payload with clear > load > drop priority.
module ex_mem_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic         drop_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (drop_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM pipeline register with valid/ready, flush, forwarding tap and saturating stall counter.
// Define EX_MEM_SKID_EN to add a skid entry so in_ready no longer depends combinationally on out_ready.
module ex_mem_pipe_reg
    import ex_mem_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int RADDR_W     = 5,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   RegWrite,
    input  logic                   MemtoReg,
    input  logic                   MemWrite,
    input  logic                   MemRead,
    input  logic [XLEN-1:0]        AluResult,
    input  logic [XLEN-1:0]        Datain,
    input  logic [RADDR_W-1:0]     Rd_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   RegWrite_Out,
    output logic                   MemtoReg_Out,
    output logic                   MemWrite_Out,
    output logic                   MemRead_Out,
    output logic [XLEN-1:0]        AluOut,
    output logic [XLEN-1:0]        DataOut,
    output logic [RADDR_W-1:0]     Rd_out,
    output logic                   fwd_valid,
    output logic [RADDR_W-1:0]     fwd_rd,
    output logic [XLEN-1:0]        fwd_data,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        ex_mem_ctrl_t        ctrl;
        logic [XLEN-1:0]     alu;
        logic [XLEN-1:0]     data;
        logic [RADDR_W-1:0]  rd;
    } ex_mem_payload_t;

    localparam int PAYLOAD_W = $bits(ex_mem_payload_t);

    ex_mem_payload_t        inPayload, mainPayload;
    ex_mem_ctrl_t           ctrlOut;
    logic                   mainValid, mainLoad, mainDrop, accept;
    ex_mem_payload_t        mainD;
    logic [STALL_CNT_W-1:0] stallCnt_q, stallCnt_d;

    always_comb begin
        inPayload               = '0;
        inPayload.ctrl.RegWrite = RegWrite;
        inPayload.ctrl.MemtoReg = MemtoReg;
        inPayload.ctrl.MemWrite = MemWrite;
        inPayload.ctrl.MemRead  = MemRead;
        inPayload.alu           = AluResult;
        inPayload.data          = Datain;
        inPayload.rd            = Rd_in;
    end

    assign accept = in_valid & in_ready & ~flush;

`ifdef EX_MEM_SKID_EN
    ex_mem_payload_t skidPayload;
    logic            skidValid, skidLoad, skidDrop, mainFree;

    // The skid entry always holds the younger instruction, so it refills main before anything new.
    assign in_ready = ~reset & ~skidValid;
    assign mainFree = ~mainValid | out_ready;
    assign mainLoad = skidValid ? out_ready : (accept & mainFree);
    assign mainD    = skidValid ? skidPayload : inPayload;
    assign mainDrop = out_ready;
    assign skidLoad = ~skidValid & accept & ~mainFree;
    assign skidDrop = skidValid & out_ready;

    ex_mem_slot #(.W(PAYLOAD_W)) u_skid (
        .clk     (clk),
        .reset   (reset),
        .clear_i (flush),
        .load_i  (skidLoad),
        .drop_i  (skidDrop),
        .data_i  (inPayload),
        .valid_o (skidValid),
        .data_o  (skidPayload)
    );
`else
    assign in_ready = ~reset & (~mainValid | out_ready);
    assign mainLoad = accept;
    assign mainD    = inPayload;
    assign mainDrop = out_ready;
`endif

    ex_mem_slot #(.W(PAYLOAD_W)) u_main (
        .clk     (clk),
        .reset   (reset),
        .clear_i (flush),
        .load_i  (mainLoad),
        .drop_i  (mainDrop),
        .data_i  (mainD),
        .valid_o (mainValid),
        .data_o  (mainPayload)
    );

    always_comb begin
        stallCnt_d = stallCnt_q;
        if (mainValid && !out_ready && (stallCnt_q != '1)) begin
            stallCnt_d = stallCnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stallCnt_q <= '0;
        end else begin
            stallCnt_q <= stallCnt_d;
        end
    end

    assign ctrlOut      = gate_ctrl(mainPayload.ctrl, mainValid);
    assign out_valid    = mainValid;
    assign RegWrite_Out = ctrlOut.RegWrite;
    assign MemtoReg_Out = ctrlOut.MemtoReg;
    assign MemWrite_Out = ctrlOut.MemWrite;
    assign MemRead_Out  = ctrlOut.MemRead;
    assign AluOut       = mainPayload.alu;
    assign DataOut      = mainPayload.data;
    assign Rd_out       = mainPayload.rd;
    // Loads are excluded: their data only exists after the memory access.
    assign fwd_valid    = ctrlOut.RegWrite & ~ctrlOut.MemtoReg & (mainPayload.rd != RADDR_W'(ZERO_REG));
    assign fwd_rd       = mainPayload.rd;
    assign fwd_data     = mainPayload.alu;
    assign stall_cnt    = stallCnt_q;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Scoreboard bench for ex_mem_pipe_reg: accepted entries are queued, a negedge monitor checks delivery order.
module tb_ex_mem_pipe_reg;

    localparam int XLEN        = 64;
    localparam int RADDR_W     = 5;
    localparam int STALL_CNT_W = 4;

    typedef struct packed {
        logic               rw;
        logic               mtr;
        logic               mw;
        logic               mr;
        logic [XLEN-1:0]    alu;
        logic [XLEN-1:0]    data;
        logic [RADDR_W-1:0] rd;
    } tbEntry_t;

    logic clk = 1'b0;
    logic reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic RegWrite, MemtoReg, MemWrite, MemRead;
    logic RegWrite_Out, MemtoReg_Out, MemWrite_Out, MemRead_Out;
    logic [XLEN-1:0] AluResult, Datain, AluOut, DataOut, fwd_data;
    logic [RADDR_W-1:0] Rd_in, Rd_out, fwd_rd;
    logic fwd_valid;
    logic [STALL_CNT_W-1:0] stall_cnt;

    tbEntry_t curEntry;
    tbEntry_t expQ[$];
    int checks = 0;
    int errors = 0;
    bit randReady = 1'b0;

    always #5 clk = ~clk;

    ex_mem_pipe_reg #(
        .XLEN(XLEN), .RADDR_W(RADDR_W), .STALL_CNT_W(STALL_CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .RegWrite(RegWrite), .MemtoReg(MemtoReg), .MemWrite(MemWrite), .MemRead(MemRead),
        .AluResult(AluResult), .Datain(Datain), .Rd_in(Rd_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .RegWrite_Out(RegWrite_Out), .MemtoReg_Out(MemtoReg_Out),
        .MemWrite_Out(MemWrite_Out), .MemRead_Out(MemRead_Out),
        .AluOut(AluOut), .DataOut(DataOut), .Rd_out(Rd_out),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .stall_cnt(stall_cnt)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input tbEntry_t e);
        curEntry  = e;
        RegWrite  = e.rw;
        MemtoReg  = e.mtr;
        MemWrite  = e.mw;
        MemRead   = e.mr;
        AluResult = e.alu;
        Datain    = e.data;
        Rd_in     = e.rd;
        in_valid  = 1'b1;
    endtask

    // One clock: record an accept (or squash) at negedge, return 1 time unit after the posedge.
    task automatic stepCycle();
        logic accepted;
        if (randReady) out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        accepted = in_valid && in_ready && !flush && !reset;
        if (reset || flush) expQ.delete();
        if (accepted) expQ.push_back(curEntry);
        @(posedge clk);
        #1;
        if (accepted) in_valid = 1'b0;
    endtask

    task automatic waitAccept(input string name);
        int n = 0;
        while (in_valid && n < 30) begin
            stepCycle();
            n++;
        end
        if (in_valid) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: entry not accepted within %0d cycles", name, n);
            in_valid = 1'b0;
        end
    endtask

    task automatic sendEntry(input string name, input tbEntry_t e);
        applyStimulus(e);
        waitAccept(name);
    endtask

    task automatic drain(input string name);
        int n = 0;
        out_ready = 1'b1;
        while (expQ.size() != 0 && n < 50) begin
            stepCycle();
            n++;
        end
        checkOutput(name, 64'(expQ.size()), 64'd0);
    endtask

    // Monitor: every handshake must match the oldest accepted entry; bubbles must carry no control.
    initial begin
        tbEntry_t e;
        forever begin
            @(negedge clk);
            if (!reset && !flush && out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_output: got alu %0h with empty scoreboard", AluOut);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("mon_alu", AluOut, e.alu);
                    checkOutput("mon_data", DataOut, e.data);
                    checkOutput("mon_rd", 64'(Rd_out), 64'(e.rd));
                    checkOutput("mon_ctrl", {RegWrite_Out, MemtoReg_Out, MemWrite_Out, MemRead_Out},
                                {e.rw, e.mtr, e.mw, e.mr});
                    checkOutput("mon_fwd_valid", 64'(fwd_valid), 64'(e.rw && !e.mtr && (e.rd != 0)));
                    checkOutput("mon_fwd_rd", 64'(fwd_rd), 64'(e.rd));
                    checkOutput("mon_fwd_data", fwd_data, e.alu);
                end
            end
            if (out_valid === 1'b0) begin
                checkOutput("bubble_ctrl", {RegWrite_Out, MemtoReg_Out, MemWrite_Out, MemRead_Out, fwd_valid}, 64'd0);
            end
        end
    end

    initial begin
        tbEntry_t e;
        reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
        e = '{rw:1'b1, mtr:1'b0, mw:1'b1, mr:1'b0, alu:64'hDEAD, data:64'hF00D, rd:5'd9};
        applyStimulus(e);
        @(posedge clk);
        #1;

        // T1: reset held two cycles with in_valid high
        stepCycle();
        stepCycle();
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_ctrl", {RegWrite_Out, MemtoReg_Out, MemWrite_Out, MemRead_Out}, 64'd0);
        checkOutput("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
        checkOutput("rst_alu", AluOut, 64'd0);
        checkOutput("rst_rd", 64'(Rd_out), 64'd0);
        reset = 1'b0;
        in_valid = 1'b0;

        // T2: pass-through with one-cycle latency
        e = '{rw:1'b1, mtr:1'b0, mw:1'b0, mr:1'b0, alu:64'h1234, data:64'hBEEF, rd:5'd5};
        sendEntry("t2_accept", e);
        checkOutput("t2_out_valid", 64'(out_valid), 64'd1);
        checkOutput("t2_alu", AluOut, 64'h1234);
        checkOutput("t2_fwd_valid", 64'(fwd_valid), 64'd1);
        drain("t2_drain");

        // T3: three stall cycles with a new EX entry waiting
        out_ready = 1'b0;
        e = '{rw:1'b1, mtr:1'b0, mw:1'b0, mr:1'b0, alu:64'hA1, data:64'hA2, rd:5'd3};
        sendEntry("t3_accept_a", e);
        e = '{rw:1'b0, mtr:1'b0, mw:1'b1, mr:1'b0, alu:64'hB1, data:64'hB2, rd:5'd4};
        applyStimulus(e);
        for (int i = 0; i < 3; i++) stepCycle();
        checkOutput("t3_frozen_alu", AluOut, 64'hA1);
        checkOutput("t3_frozen_rd", 64'(Rd_out), 64'd3);
        checkOutput("t3_stall_cnt", 64'(stall_cnt), 64'd3);
        checkOutput("t3_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        waitAccept("t3_accept_b");
        drain("t3_drain");

        // T4: flush while stalled, with another entry offered in the same cycle
        out_ready = 1'b0;
        e = '{rw:1'b0, mtr:1'b0, mw:1'b1, mr:1'b0, alu:64'hC1, data:64'hC2, rd:5'd0};
        sendEntry("t4_accept", e);
        checkOutput("t4_memwrite_held", 64'(MemWrite_Out), 64'd1);
        e = '{rw:1'b1, mtr:1'b0, mw:1'b0, mr:1'b0, alu:64'hD1, data:64'hD2, rd:5'd6};
        applyStimulus(e);
        flush = 1'b1;
        stepCycle();
        flush = 1'b0;
        in_valid = 1'b0;
        checkOutput("t4_out_valid", 64'(out_valid), 64'd0);
        checkOutput("t4_memwrite", 64'(MemWrite_Out), 64'd0);
        checkOutput("t4_stall_cnt", 64'(stall_cnt), 64'd4);
        out_ready = 1'b1;
        stepCycle();
        stepCycle();
        checkOutput("t4_stays_empty", 64'(out_valid), 64'd0);

        // T5: x0 destination and load never forward
        e = '{rw:1'b1, mtr:1'b0, mw:1'b0, mr:1'b0, alu:64'h55, data:64'h66, rd:5'd0};
        sendEntry("t5_x0", e);
        checkOutput("t5_x0_fwd", 64'(fwd_valid), 64'd0);
        e = '{rw:1'b1, mtr:1'b1, mw:1'b0, mr:1'b1, alu:64'h77, data:64'h88, rd:5'd7};
        sendEntry("t5_load", e);
        checkOutput("t5_load_fwd", 64'(fwd_valid), 64'd0);
        checkOutput("t5_memread", 64'(MemRead_Out), 64'd1);
        drain("t5_drain");

        // T6: saturation, reset mid-stall, then back-to-back entries under random out_ready
        reset = 1'b1;
        stepCycle();
        reset = 1'b0;
        checkOutput("t6_cnt_cleared", 64'(stall_cnt), 64'd0);
        out_ready = 1'b0;
        e = '{rw:1'b1, mtr:1'b0, mw:1'b0, mr:1'b0, alu:64'hE1, data:64'hE2, rd:5'd8};
        sendEntry("t6_accept", e);
        for (int i = 0; i < 15; i++) stepCycle();
        checkOutput("t6_cnt_15", 64'(stall_cnt), 64'd15);
        for (int i = 0; i < 5; i++) stepCycle();
        checkOutput("t6_cnt_sat", 64'(stall_cnt), 64'd15);
        reset = 1'b1;
        stepCycle();
        reset = 1'b0;
        checkOutput("t6_rst_valid", 64'(out_valid), 64'd0);
        checkOutput("t6_rst_cnt", 64'(stall_cnt), 64'd0);

        randReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            e = '{rw:1'(i % 2), mtr:1'b0, mw:1'(i == 2), mr:1'b0,
                  alu:64'(32'h100 + i), data:64'(32'h200 + i), rd:5'(i + 1)};
            sendEntry("t6_burst", e);
        end
        randReady = 1'b0;
        drain("t6_drain");
        stepCycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
